// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces the active-low KEY pushbuttons, then
// produces a clean PIO level plus one-cycle press, release and optional auto-repeat pulses.
//
// Ports:
//   clk_clk            system clock (50 MHz domain)
//   reset_reset        asynchronous active-high reset
//   key_raw            raw board KEY pins, active-low, asynchronous to clk_clk
//   pushbuttons_export debounced level in board polarity (0 = pressed), to the PIO
//   pressed_pulse      1-cycle pulse when a debounced level goes 1->0
//   released_pulse     1-cycle pulse when a debounced level goes 0->1
//   repeat_pulse       1-cycle auto-repeat pulse while a button stays held
//
// Build option: define BUTTON_AUTOREPEAT_EN to build the per-channel repeat FSMs;
// without it repeat_pulse is tied to 0 and no repeat logic exists.
module button_conditioner #(
  parameter int NUM_BUTTONS         = 4,
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 5000000
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic [NUM_BUTTONS-1:0] key_raw,
  output logic [NUM_BUTTONS-1:0] pushbuttons_export,
  output logic [NUM_BUTTONS-1:0] pressed_pulse,
  output logic [NUM_BUTTONS-1:0] released_pulse,
  output logic [NUM_BUTTONS-1:0] repeat_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_repeat
    $error("repeat intervals must be at least 1 cycle");
  end
  logic [NUM_BUTTONS-1:0] r_s1, r_s2;
  logic [DW-1:0]          r_db_cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] w_flip, w_press, w_release;
  // A channel flips on the edge where its mismatch has persisted for DEBOUNCE_CYCLES edges.
  always_comb begin
    w_flip = '0;
    for (int n = 0; n < NUM_BUTTONS; n++)
      w_flip[n] = (r_s2[n] != pushbuttons_export[n]) && (r_db_cnt[n] == DB_LAST);
  end
  assign w_press   = w_flip & ~r_s2;
  assign w_release = w_flip & r_s2;
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      r_s1               <= '1;
      r_s2               <= '1;
      pushbuttons_export <= '1;
      pressed_pulse      <= '0;
      released_pulse     <= '0;
      for (int n = 0; n < NUM_BUTTONS; n++) r_db_cnt[n] <= '0;
    end else begin
      r_s1               <= key_raw;
      r_s2               <= r_s1;
      pushbuttons_export <= pushbuttons_export ^ w_flip;
      pressed_pulse      <= w_press;
      released_pulse     <= w_release;
      for (int n = 0; n < NUM_BUTTONS; n++)
        r_db_cnt[n] <= (r_s2[n] == pushbuttons_export[n] || w_flip[n]) ? '0 : r_db_cnt[n] + DW'(1);
    end
`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ? REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;
  rpt_state_t      r_state   [NUM_BUTTONS];
  logic [RW-1:0]   r_rpt_cnt [NUM_BUTTONS];
  // Release is checked first so it wins over a coincident terminal count.
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      repeat_pulse <= '0;
      for (int n = 0; n < NUM_BUTTONS; n++) begin
        r_state[n]   <= IDLE;
        r_rpt_cnt[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_BUTTONS; n++) begin
        repeat_pulse[n] <= 1'b0;
        if (w_release[n]) begin
          r_state[n]   <= IDLE;
          r_rpt_cnt[n] <= '0;
        end else begin
          case (r_state[n])
            IDLE: if (w_press[n]) begin
              r_state[n]   <= DELAY;
              r_rpt_cnt[n] <= '0;
            end
            DELAY: if (r_rpt_cnt[n] == DELAY_LAST) begin
              repeat_pulse[n] <= 1'b1;
              r_state[n]      <= REPEAT;
              r_rpt_cnt[n]    <= '0;
            end else r_rpt_cnt[n] <= r_rpt_cnt[n] + RW'(1);
            REPEAT: if (r_rpt_cnt[n] == RATE_LAST) begin
              repeat_pulse[n] <= 1'b1;
              r_rpt_cnt[n]    <= '0;
            end else r_rpt_cnt[n] <= r_rpt_cnt[n] + RW'(1);
            default: r_state[n] <= IDLE;
          endcase
        end
      end
    end
`else
  assign repeat_pulse = '0;
`endif
endmodule
